motor_pwm_decode: RTL

- Reader side of the motor H-bridge drive interface: observes one channel's fwd/rev PWM pair and reconstructs the signed 11-bit speed command that produced it.
- Used as an in-system monitor and loopback checker: the decoded value is compared against the commanded rht/lft value, and brake and illegal-overlap conditions are flagged.
- One instance per motor channel.

---
 rtl/motor_pwm_decode.sv | 116 +++++++++++
 1 files changed

// File: rtl/motor_pwm_decode.sv
// motor_pwm_decode: rebuilds the signed speed command from one channel's fwd/rev PWM pair and flags brake/overlap; define SYNC_INPUTS_EN for 2-flop input synchronizers
module motor_pwm_decode #(
  parameter int PWM_W  = 10,
  parameter int DUTY_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fwd,
  input  logic              rev,
  input  logic              en,
  output logic [DUTY_W-1:0] duty,
  output logic              vld,
  output logic              brake,
  output logic              fault
);
  typedef enum logic [1:0] {IDLE, MEAS, REPORT} state_t;
  localparam logic [PWM_W:0] FULL = {1'b1, {PWM_W{1'b0}}};
  logic fwd_s, rev_s;
`ifdef SYNC_INPUTS_EN
  logic [1:0] fwd_sync_q, rev_sync_q;
  // two-flop synchronizers on the PWM lines before they are sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sync_q <= '0;
      rev_sync_q <= '0;
    end else begin
      fwd_sync_q <= {fwd_sync_q[0], fwd};
      rev_sync_q <= {rev_sync_q[0], rev};
    end
  end
  assign fwd_s = fwd_sync_q[1];
  assign rev_s = rev_sync_q[1];
`else
  assign fwd_s = fwd;
  assign rev_s = rev;
`endif
  state_t state_q, state_d;
  logic [PWM_W-1:0] wcnt_q, wcnt_d, fmag, rmag;
  logic [PWM_W:0] fcnt_q, fcnt_d, rcnt_q, rcnt_d, bcnt_q, bcnt_d, f_inc, r_inc, b_inc;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic vld_q, vld_d, brake_q, brake_d, fault_q, fault_d;
  assign f_inc = {{PWM_W{1'b0}}, fwd_s & ~rev_s};
  assign r_inc = {{PWM_W{1'b0}}, rev_s & ~fwd_s};
  assign b_inc = {{PWM_W{1'b0}}, fwd_s & rev_s};
  assign fmag  = fcnt_q[PWM_W] ? '1 : fcnt_q[PWM_W-1:0];
  assign rmag  = rcnt_q[PWM_W] ? '1 : rcnt_q[PWM_W-1:0];
  // window sequencing, per-line accumulation and end-of-window decode
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    bcnt_d  = bcnt_q;
    duty_d  = duty_q;
    vld_d   = 1'b0;
    brake_d = brake_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        state_d = en ? MEAS : IDLE;
        wcnt_d  = '0;
        fcnt_d  = '0;
        rcnt_d  = '0;
        bcnt_d  = '0;
      end
      MEAS: begin
        state_d = !en ? IDLE : wcnt_q == '1 ? REPORT : MEAS;
        wcnt_d  = wcnt_q + PWM_W'(1);
        fcnt_d  = fcnt_q + f_inc;
        rcnt_d  = rcnt_q + r_inc;
        bcnt_d  = bcnt_q + b_inc;
      end
      REPORT: begin
        brake_d = bcnt_q == FULL;
        fault_d = !brake_d && (bcnt_q != '0 || (fcnt_q != '0 && rcnt_q != '0));
        duty_d  = brake_d ? '0 : fault_d ? duty_q :
                  rcnt_q != '0 ? DUTY_W'(-{1'b0, rmag}) : DUTY_W'({1'b0, fmag});
        vld_d   = 1'b1;
        state_d = en ? MEAS : IDLE;
        wcnt_d  = PWM_W'(1);
        fcnt_d  = f_inc;
        rcnt_d  = r_inc;
        bcnt_d  = b_inc;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      duty_q  <= '0;
      vld_q   <= 1'b0;
      brake_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      duty_q  <= duty_d;
      vld_q   <= vld_d;
      brake_q <= brake_d;
      fault_q <= fault_d;
    end
  end
  assign duty  = duty_q;
  assign vld   = vld_q;
  assign brake = brake_q;
  assign fault = fault_q;
endmodule
